// File: rtl/rgb_led_sequencer_if.sv
// Command channel into the RGB LED sequencer: target colour plus fade rate
// over a valid/ready handshake.
interface rgb_led_sequencer_if #(
  parameter int unsigned PWM_BITS = 8
) ();
  logic                cmd_valid;
  logic                cmd_ready;
  logic [PWM_BITS-1:0] cmd_red;
  logic [PWM_BITS-1:0] cmd_green;
  logic [PWM_BITS-1:0] cmd_blue;
  logic [7:0]          cmd_rate;

  modport master (
    output cmd_valid, cmd_red, cmd_green, cmd_blue, cmd_rate,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_red, cmd_green, cmd_blue, cmd_rate,
    output cmd_ready
  );
endinterface

// File: rtl/rgb_led_sequencer.sv
// Sequencer for the iCE40 SB_RGBA_DRV: enables CURREN, waits for it to
// settle, enables RGBLEDEN, fades the three channel levels linearly towards
// the commanded targets and drives the RGBxPWM inputs.
// Optional: define RGB_SEQ_GAMMA_EN for squared (gamma ~2) duty mapping.
module rgb_led_sequencer #(
  parameter int unsigned PWM_BITS      = 8,
  parameter int unsigned SETTLE_CYCLES = 4800,
  parameter int unsigned STEP_CYCLES   = 48000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  rgb_led_sequencer_if.slave      cmd,
  output logic                    busy,
  output logic                    curren,
  output logic                    rgbleden,
  output logic                    red_pwm,
  output logic                    green_pwm,
  output logic                    blue_pwm
);

  localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned STEP_W   = $clog2(STEP_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_OFF, ST_SETTLE, ST_FADE, ST_IDLE, ST_DRAIN
  } state_e;

  state_e              state_q, state_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [STEP_W-1:0]   pre_q, pre_d;
  logic [7:0]          rcnt_q, rcnt_d;
  logic [7:0]          rate_q, rate_d;
  logic [PWM_BITS-1:0] red_lvl_q, red_lvl_d, green_lvl_q, green_lvl_d, blue_lvl_q, blue_lvl_d;
  logic [PWM_BITS-1:0] red_tgt_q, red_tgt_d, green_tgt_q, green_tgt_d, blue_tgt_q, blue_tgt_d;
  logic                curren_q, curren_d, rgbleden_q, rgbleden_d;
  logic                busy_q, busy_d, ready_q, ready_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                red_pwm_q, red_pwm_d, green_pwm_q, green_pwm_d, blue_pwm_q, blue_pwm_d;
  logic [PWM_BITS-1:0] red_duty, green_duty, blue_duty;

  logic accept, latch, cmd_zero, tgt_zero, at_tgt, tick;

  // Move a level one unit towards its target, never past it.
  function automatic logic [PWM_BITS-1:0] step_toward(input logic [PWM_BITS-1:0] lvl,
                                                      input logic [PWM_BITS-1:0] tgt);
    if (lvl < tgt)      return lvl + 1'b1;
    else if (lvl > tgt) return lvl - 1'b1;
    else                return lvl;
  endfunction

  // Next-state, sequencing and fade arithmetic.
  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    pre_d       = pre_q;
    rcnt_d      = rcnt_q;
    rate_d      = rate_q;
    red_lvl_d   = red_lvl_q;
    green_lvl_d = green_lvl_q;
    blue_lvl_d  = blue_lvl_q;
    red_tgt_d   = red_tgt_q;
    green_tgt_d = green_tgt_q;
    blue_tgt_d  = blue_tgt_q;
    curren_d    = curren_q;
    rgbleden_d  = rgbleden_q;
    latch       = 1'b0;

    accept   = cmd.cmd_valid && ready_q;
    cmd_zero = (cmd.cmd_red == '0) && (cmd.cmd_green == '0) && (cmd.cmd_blue == '0);
    tgt_zero = (red_tgt_q == '0) && (green_tgt_q == '0) && (blue_tgt_q == '0);
    at_tgt   = (red_lvl_q == red_tgt_q) && (green_lvl_q == green_tgt_q) &&
               (blue_lvl_q == blue_tgt_q);
    tick     = (pre_q == STEP_W'(STEP_CYCLES - 1));

    case (state_q)
      ST_OFF: begin
        if (accept && !cmd_zero) begin
          latch    = 1'b1;
          curren_d = 1'b1;
          settle_d = SETTLE_W'(SETTLE_CYCLES - 1);
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_q == '0) begin
          rgbleden_d = 1'b1;
          pre_d      = '0;
          rcnt_d     = '0;
          state_d    = ST_FADE;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      ST_IDLE: begin
        if (accept) begin
          latch   = 1'b1;
          pre_d   = '0;
          rcnt_d  = '0;
          state_d = ST_FADE;
        end
      end
      ST_FADE: begin
        if (at_tgt) begin
          if (tgt_zero) begin
            rgbleden_d = 1'b0;
            state_d    = ST_DRAIN;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (rate_q == '0) begin
          red_lvl_d   = red_tgt_q;
          green_lvl_d = green_tgt_q;
          blue_lvl_d  = blue_tgt_q;
        end else begin
          pre_d = tick ? '0 : pre_q + 1'b1;
          if (tick) begin
            if (rcnt_q == rate_q - 8'd1) begin
              rcnt_d      = '0;
              red_lvl_d   = step_toward(red_lvl_q, red_tgt_q);
              green_lvl_d = step_toward(green_lvl_q, green_tgt_q);
              blue_lvl_d  = step_toward(blue_lvl_q, blue_tgt_q);
            end else begin
              rcnt_d = rcnt_q + 8'd1;
            end
          end
        end
      end
      ST_DRAIN: begin
        curren_d = 1'b0;
        state_d  = ST_OFF;
      end
      default: state_d = ST_OFF;
    endcase

    if (latch) begin
      red_tgt_d   = cmd.cmd_red;
      green_tgt_d = cmd.cmd_green;
      blue_tgt_d  = cmd.cmd_blue;
      rate_d      = cmd.cmd_rate;
    end

    busy_d  = (state_d == ST_SETTLE) || (state_d == ST_FADE) || (state_d == ST_DRAIN);
    ready_d = (state_d == ST_OFF) || (state_d == ST_IDLE);

    pwm_cnt_d   = pwm_cnt_q + 1'b1;
    red_pwm_d   = rgbleden_q && (pwm_cnt_q < red_duty);
    green_pwm_d = rgbleden_q && (pwm_cnt_q < green_duty);
    blue_pwm_d  = rgbleden_q && (pwm_cnt_q < blue_duty);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_OFF;
      settle_q    <= '0;
      pre_q       <= '0;
      rcnt_q      <= '0;
      rate_q      <= '0;
      red_lvl_q   <= '0;
      green_lvl_q <= '0;
      blue_lvl_q  <= '0;
      red_tgt_q   <= '0;
      green_tgt_q <= '0;
      blue_tgt_q  <= '0;
      curren_q    <= 1'b0;
      rgbleden_q  <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
      pwm_cnt_q   <= '0;
      red_pwm_q   <= 1'b0;
      green_pwm_q <= 1'b0;
      blue_pwm_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      pre_q       <= pre_d;
      rcnt_q      <= rcnt_d;
      rate_q      <= rate_d;
      red_lvl_q   <= red_lvl_d;
      green_lvl_q <= green_lvl_d;
      blue_lvl_q  <= blue_lvl_d;
      red_tgt_q   <= red_tgt_d;
      green_tgt_q <= green_tgt_d;
      blue_tgt_q  <= blue_tgt_d;
      curren_q    <= curren_d;
      rgbleden_q  <= rgbleden_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
      pwm_cnt_q   <= pwm_cnt_d;
      red_pwm_q   <= red_pwm_d;
      green_pwm_q <= green_pwm_d;
      blue_pwm_q  <= blue_pwm_d;
    end
  end

`ifdef RGB_SEQ_GAMMA_EN
  logic [PWM_BITS-1:0] red_duty_q, red_duty_d, green_duty_q, green_duty_d, blue_duty_q, blue_duty_d;

  // Upper half of level squared: approximate perceptual brightness curve.
  function automatic logic [PWM_BITS-1:0] gamma_map(input logic [PWM_BITS-1:0] lvl);
    logic [2*PWM_BITS-1:0] sq;
    sq = (2*PWM_BITS)'(lvl) * (2*PWM_BITS)'(lvl);
    return sq[2*PWM_BITS-1:PWM_BITS];
  endfunction

  // Gamma-mapped duty, computed from the current levels.
  always_comb begin
    red_duty_d   = gamma_map(red_lvl_q);
    green_duty_d = gamma_map(green_lvl_q);
    blue_duty_d  = gamma_map(blue_lvl_q);
  end

  // Duty pipeline register (adds one cycle of level->pwm latency).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      red_duty_q   <= '0;
      green_duty_q <= '0;
      blue_duty_q  <= '0;
    end else begin
      red_duty_q   <= red_duty_d;
      green_duty_q <= green_duty_d;
      blue_duty_q  <= blue_duty_d;
    end
  end

  assign red_duty   = red_duty_q;
  assign green_duty = green_duty_q;
  assign blue_duty  = blue_duty_q;
`else
  assign red_duty   = red_lvl_q;
  assign green_duty = green_lvl_q;
  assign blue_duty  = blue_lvl_q;
`endif

  assign cmd.cmd_ready = ready_q;
  assign busy          = busy_q;
  assign curren        = curren_q;
  assign rgbleden      = rgbleden_q;
  assign red_pwm       = red_pwm_q;
  assign green_pwm     = green_pwm_q;
  assign blue_pwm      = blue_pwm_q;

endmodule

// File: tb/tb_rgb_led_sequencer.sv
// Directed bench for rgb_led_sequencer with short settle/step periods.
module tb_rgb_led_sequencer;

  localparam int unsigned PWM_BITS = 8;
  localparam int unsigned SETTLE   = 16;
  localparam int unsigned STEP     = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic busy, curren, rgbleden, red_pwm, green_pwm, blue_pwm;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rgb_led_sequencer_if #(.PWM_BITS(PWM_BITS)) cmd_if ();

  rgb_led_sequencer #(
    .PWM_BITS(PWM_BITS), .SETTLE_CYCLES(SETTLE), .STEP_CYCLES(STEP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd_if), .busy(busy), .curren(curren),
    .rgbleden(rgbleden), .red_pwm(red_pwm), .green_pwm(green_pwm), .blue_pwm(blue_pwm)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_duty(input int lvl);
`ifdef RGB_SEQ_GAMMA_EN
    return (lvl * lvl) >> 8;
`else
    return lvl;
`endif
  endfunction

  // Present a command and return just after the edge that accepts it.
  task automatic send(input int r, input int g, input int b, input int rate);
    logic rdy;
    bit   done;
    done = 1'b0;
    cmd_if.cmd_red   = 8'(r);
    cmd_if.cmd_green = 8'(g);
    cmd_if.cmd_blue  = 8'(b);
    cmd_if.cmd_rate  = 8'(rate);
    cmd_if.cmd_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      rdy = cmd_if.cmd_ready;
      tick();
      if (rdy) done = 1'b1;
    end
    cmd_if.cmd_valid = 1'b0;
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic wait_idle(output int k);
    k = 0;
    while (busy && k < 2000) begin
      tick();
      k++;
    end
    if (busy) check("idle_timeout", 1, 0);
  endtask

  // Count high cycles of each PWM output over one full period.
  task automatic measure(output int r, output int g, output int b);
    r = 0; g = 0; b = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      r += int'(red_pwm);
      g += int'(green_pwm);
      b += int'(blue_pwm);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, kr, kc, r, g, b, act;
    logic rdy;
    bit done;

    rst_n = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_red = '0; cmd_if.cmd_green = '0; cmd_if.cmd_blue = '0; cmd_if.cmd_rate = '0;
    tick(); tick();
    check("rst_curren", int'(curren), 0);
    check("rst_rgbleden", int'(rgbleden), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(cmd_if.cmd_ready), 1);
    check("rst_pwm", int'(red_pwm | green_pwm | blue_pwm), 0);
    act = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      act += int'(red_pwm | green_pwm | blue_pwm | rgbleden | curren);
    end
    check("rst_hold_activity", act, 0);
    rst_n = 1'b1;
    tick();

    // All-zero command while off is ignored.
    send(0, 0, 0, 0);
    tick(); tick(); tick();
    check("off_zero_curren", int'(curren), 0);
    check("off_zero_busy", int'(busy), 0);
    check("off_zero_ready", int'(cmd_if.cmd_ready), 1);

    // Power-up sequence with a jump to red 128.
    send(128, 0, 0, 0);
    check("pu_curren", int'(curren), 1);
    check("pu_rgbleden_early", int'(rgbleden), 0);
    check("pu_busy", int'(busy), 1);
    check("pu_ready", int'(cmd_if.cmd_ready), 0);
    k = 0;
    while (!rgbleden && k < 40) begin
      tick();
      k++;
    end
    check("settle_cycles", k, 16);
    wait_idle(k);
    check("jump_cycles", k, 2);
    measure(r, g, b);
    check("duty128_red", r, exp_duty(128));
    check("duty128_green", g, 0);
    check("duty128_blue", b, 0);

    // Linear fade from (10,10,10) to (13,10,7), one step per prescaler tick.
    send(10, 10, 10, 0);
    wait_idle(k);
    send(13, 10, 7, 1);
    wait_idle(k);
    check("fade_cycles", k, 13);
    check("fade_ready", int'(cmd_if.cmd_ready), 1);
    measure(r, g, b);
    check("fade_red", r, exp_duty(13));
    check("fade_green", g, exp_duty(10));
    check("fade_blue", b, exp_duty(7));

    // A command held during a fade waits for IDLE (13 steps * 4 + 1 exit + 1 accept).
    send(20, 20, 20, 1);
    cmd_if.cmd_red = 8'd50; cmd_if.cmd_green = 8'd50; cmd_if.cmd_blue = 8'd50;
    cmd_if.cmd_rate = 8'd0;
    cmd_if.cmd_valid = 1'b1;
    check("held_ready_low", int'(cmd_if.cmd_ready), 0);
    k = 0;
    done = 1'b0;
    while (!done && k < 200) begin
      rdy = cmd_if.cmd_ready;
      tick();
      k++;
      if (rdy) done = 1'b1;
    end
    cmd_if.cmd_valid = 1'b0;
    check("held_accept_edge", k, 54);
    wait_idle(k);
    measure(r, g, b);
    check("held_red", r, exp_duty(50));
    check("held_blue", b, exp_duty(50));

    // Fade to black: rgbleden drops, curren one cycle later.
    send(0, 0, 0, 0);
    kr = -1; kc = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (kr < 0 && !rgbleden) kr = i;
      if (kc < 0 && !curren) kc = i;
    end
    check("drain_rgbleden_fall", kr, 2);
    check("drain_curren_fall", kc, 3);
    check("drain_busy", int'(busy), 0);
    check("drain_ready", int'(cmd_if.cmd_ready), 1);
    check("drain_pwm", int'(red_pwm | green_pwm | blue_pwm), 0);

    // Reset in the middle of a slow fade aborts at once.
    send(128, 128, 128, 0);
    wait_idle(k);
    send(0, 0, 0, 200);
    for (int i = 0; i < 10; i++) tick();
    check("midfade_busy", int'(busy), 1);
    rst_n = 1'b0;
    tick();
    check("midrst_curren", int'(curren), 0);
    check("midrst_rgbleden", int'(rgbleden), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_ready", int'(cmd_if.cmd_ready), 1);
    check("midrst_pwm", int'(red_pwm | green_pwm | blue_pwm), 0);
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
